// File: rtl/traffic_light_controller.sv
// Two-road traffic light phase sequencer: init -> green/yellow alternation,
// with a blinking-yellow fallback when the roads go idle.
module traffic_light_controller #(
    parameter int INIT_TIME   = 4,
    parameter int GREEN_MIN   = 20,
    parameter int YELLOW_TIME = 5,
    parameter int IDLE_LIMIT  = 100,
    parameter int BACK_LIMIT  = 3,
    parameter int BLINK_HALF  = 8
) (
    input  logic       CLK,
    input  logic       Reset_n,
    input  logic       A_Traffic,
    input  logic       B_Traffic,
    input  logic [6:0] Traffic_gone,
    input  logic [3:0] Traffic_Back,
    output logic [2:0] state,
    output logic [1:0] LightA,
    output logic [1:0] LightB
);

    localparam logic [2:0] S_INIT    = 3'd0;
    localparam logic [2:0] S_A_YEL   = 3'd1;
    localparam logic [2:0] S_B_YEL   = 3'd2;
    localparam logic [2:0] S_A_GREEN = 3'd3;
    localparam logic [2:0] S_B_GREEN = 3'd4;
    localparam logic [2:0] S_BLINK   = 3'd5;

    localparam logic [1:0] L_OFF    = 2'b00;
    localparam logic [1:0] L_GREEN  = 2'b01;
    localparam logic [1:0] L_YELLOW = 2'b10;
    localparam logic [1:0] L_RED    = 2'b11;

    localparam logic [7:0] INIT_LAST   = 8'(INIT_TIME - 1);
    localparam logic [7:0] GREEN_LAST  = 8'(GREEN_MIN - 1);
    localparam logic [7:0] YELLOW_LAST = 8'(YELLOW_TIME - 1);
    localparam logic [7:0] BLINK_LAST  = 8'(BLINK_HALF - 1);
    localparam logic [6:0] IDLE_LIM    = 7'(IDLE_LIMIT);
    localparam logic [3:0] BACK_LIM    = 4'(BACK_LIMIT);

    logic [2:0] state_q, state_d;
    logic [7:0] timer_q, timer_d;
    logic [7:0] blink_cnt_q, blink_cnt_d;
    logic       blink_ph_q, blink_ph_d;

    logic idle_hit, back_hit;
    assign idle_hit = (Traffic_gone >= IDLE_LIM);
    assign back_hit = (Traffic_Back >= BACK_LIM);

    // Idle limit is checked first so it wins over a simultaneous request.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_INIT: begin
                if (timer_q == INIT_LAST) state_d = S_A_GREEN;
            end
            S_A_GREEN: begin
                if (idle_hit)                                   state_d = S_BLINK;
                else if (timer_q >= GREEN_LAST && B_Traffic)    state_d = S_A_YEL;
            end
            S_A_YEL: begin
                if (timer_q == YELLOW_LAST) state_d = S_B_GREEN;
            end
            S_B_GREEN: begin
                if (idle_hit)                                   state_d = S_BLINK;
                else if (timer_q >= GREEN_LAST && A_Traffic)    state_d = S_B_YEL;
            end
            S_B_YEL: begin
                if (timer_q == YELLOW_LAST) state_d = S_A_GREEN;
            end
            S_BLINK: begin
                if (back_hit) state_d = S_INIT;
            end
            default: state_d = S_INIT;
        endcase
    end

    always_comb begin
        if (state_d != state_q)   timer_d = 8'd0;
        else if (timer_q != 8'hFF) timer_d = timer_q + 8'd1;
        else                       timer_d = timer_q;
    end

    // Blink runs only while in Blink_state; entry starts on the lit half.
    always_comb begin
        blink_ph_d  = blink_ph_q;
        blink_cnt_d = blink_cnt_q;
        if (state_d != S_BLINK) begin
            blink_ph_d  = 1'b0;
            blink_cnt_d = 8'd0;
        end else if (state_q != S_BLINK) begin
            blink_ph_d  = 1'b1;
            blink_cnt_d = 8'd0;
        end else if (blink_cnt_q == BLINK_LAST) begin
            blink_ph_d  = ~blink_ph_q;
            blink_cnt_d = 8'd0;
        end else begin
            blink_cnt_d = blink_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= S_INIT;
            timer_q     <= 8'd0;
            blink_cnt_q <= 8'd0;
            blink_ph_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            blink_cnt_q <= blink_cnt_d;
            blink_ph_q  <= blink_ph_d;
        end
    end

    always_comb begin
        LightA = L_RED;
        LightB = L_RED;
        case (state_q)
            S_A_GREEN: LightA = L_GREEN;
            S_A_YEL:   LightA = L_YELLOW;
            S_B_GREEN: LightB = L_GREEN;
            S_B_YEL:   LightB = L_YELLOW;
            S_BLINK: begin
                LightA = blink_ph_q ? L_YELLOW : L_OFF;
                LightB = blink_ph_q ? L_YELLOW : L_OFF;
            end
            default: ;
        endcase
    end

    assign state = state_q;

endmodule

// File: tb/tb_traffic_light_controller.sv
// Directed bench for traffic_light_controller using default parameters.
module tb_traffic_light_controller;

    logic       CLK = 1'b0;
    logic       Reset_n;
    logic       A_Traffic;
    logic       B_Traffic;
    logic [6:0] Traffic_gone;
    logic [3:0] Traffic_Back;
    logic [2:0] state;
    logic [1:0] LightA;
    logic [1:0] LightB;

    int n_assert = 0;
    int n_fail   = 0;

    traffic_light_controller dut (
        .CLK          (CLK),
        .Reset_n      (Reset_n),
        .A_Traffic    (A_Traffic),
        .B_Traffic    (B_Traffic),
        .Traffic_gone (Traffic_gone),
        .Traffic_Back (Traffic_Back),
        .state        (state),
        .LightA       (LightA),
        .LightB       (LightB)
    );

    always #5 CLK = ~CLK;

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [2:0] s,
                              input logic [1:0] la, input logic [1:0] lb);
        n_assert++;
        assert (state === s) else begin
            n_fail++;
            $error("FAIL %s.state observed=%0d expected=%0d", tag, state, s);
        end
        n_assert++;
        assert (LightA === la) else begin
            n_fail++;
            $error("FAIL %s.LightA observed=%b expected=%b", tag, LightA, la);
        end
        n_assert++;
        assert (LightB === lb) else begin
            n_fail++;
            $error("FAIL %s.LightB observed=%b expected=%b", tag, LightB, lb);
        end
    endtask

    initial begin
        Reset_n      = 1'b0;
        A_Traffic    = 1'b0;
        B_Traffic    = 1'b0;
        Traffic_gone = 7'd0;
        Traffic_Back = 4'd0;
        #3;
        expect_out("reset_async", 3'd0, 2'b11, 2'b11);
        step(2);
        expect_out("reset_held", 3'd0, 2'b11, 2'b11);
        Reset_n   = 1'b1;
        B_Traffic = 1'b1;

        // Init lasts exactly four edges.
        step(3);
        expect_out("init_3", 3'd0, 2'b11, 2'b11);
        step(1);
        expect_out("a_green_entry", 3'd3, 2'b01, 2'b11);

        // Handover with B request held: 20 green cycles, 5 yellow.
        for (int i = 1; i < 20; i++) begin
            step(1);
            expect_out($sformatf("a_green_%0d", i), 3'd3, 2'b01, 2'b11);
        end
        step(1);
        expect_out("a_yellow_entry", 3'd1, 2'b10, 2'b11);
        Traffic_gone = 7'd100;
        for (int i = 1; i < 5; i++) begin
            step(1);
            expect_out($sformatf("a_yellow_idle_%0d", i), 3'd1, 2'b10, 2'b11);
        end
        step(1);
        expect_out("b_green_entry", 3'd4, 2'b11, 2'b01);
        Traffic_gone = 7'd0;
        B_Traffic    = 1'b0;
        A_Traffic    = 1'b1;

        step(19);
        expect_out("b_green_19", 3'd4, 2'b11, 2'b01);
        step(1);
        expect_out("b_yellow_entry", 3'd2, 2'b11, 2'b10);
        step(4);
        expect_out("b_yellow_4", 3'd2, 2'b11, 2'b10);
        step(1);
        expect_out("a_green_again", 3'd3, 2'b01, 2'b11);
        A_Traffic = 1'b0;

        // Late request, and again after the phase timer must have saturated.
        step(40);
        expect_out("late_40", 3'd3, 2'b01, 2'b11);
        step(230);
        expect_out("late_270", 3'd3, 2'b01, 2'b11);
        B_Traffic = 1'b1;
        step(1);
        expect_out("late_leave", 3'd1, 2'b10, 2'b11);
        B_Traffic = 1'b0;
        A_Traffic = 1'b1;
        step(5);
        expect_out("b_green_2", 3'd4, 2'b11, 2'b01);
        step(20);
        expect_out("b_yellow_2", 3'd2, 2'b11, 2'b10);
        A_Traffic = 1'b0;
        step(5);
        expect_out("a_green_3", 3'd3, 2'b01, 2'b11);

        // Idle drop at timer 3, then blink cadence 8 lit / 8 dark.
        step(3);
        expect_out("pre_idle", 3'd3, 2'b01, 2'b11);
        Traffic_gone = 7'd100;
        step(1);
        expect_out("blink_entry", 3'd5, 2'b10, 2'b10);
        Traffic_gone = 7'd0;
        step(7);
        expect_out("blink_lit_7", 3'd5, 2'b10, 2'b10);
        step(1);
        expect_out("blink_dark_0", 3'd5, 2'b00, 2'b00);
        step(7);
        expect_out("blink_dark_7", 3'd5, 2'b00, 2'b00);
        step(1);
        expect_out("blink_lit_again", 3'd5, 2'b10, 2'b10);

        // Blink exit threshold.
        Traffic_Back = 4'd2;
        for (int i = 0; i < 10; i++) begin
            step(1);
            n_assert++;
            assert (state === 3'd5) else begin
                n_fail++;
                $error("FAIL back2_%0d.state observed=%0d expected=5", i, state);
            end
        end
        Traffic_Back = 4'd3;
        step(1);
        expect_out("blink_exit", 3'd0, 2'b11, 2'b11);
        Traffic_Back = 4'd0;
        step(4);
        expect_out("restart_green", 3'd3, 2'b01, 2'b11);

        // Reach B yellow, then reset asynchronously mid-phase.
        B_Traffic = 1'b1;
        step(20);
        expect_out("to_a_yellow", 3'd1, 2'b10, 2'b11);
        B_Traffic = 1'b0;
        A_Traffic = 1'b1;
        step(25);
        expect_out("to_b_yellow", 3'd2, 2'b11, 2'b10);
        step(2);
        expect_out("mid_b_yellow", 3'd2, 2'b11, 2'b10);
        A_Traffic = 1'b0;
        #2;
        Reset_n = 1'b0;
        #1;
        expect_out("async_reset_mid", 3'd0, 2'b11, 2'b11);
        step(2);
        Reset_n = 1'b1;
        step(3);
        expect_out("post_reset_init_3", 3'd0, 2'b11, 2'b11);
        step(1);
        expect_out("post_reset_green", 3'd3, 2'b01, 2'b11);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/traffic_light_controller.md
# traffic_light_controller

- Main phase sequencer of the traffic-light system; drives the two light heads for roads A and B.
- Consumes the road sensors and the idle/return counters from the traffic monitor (`Traffic_gone`, `Traffic_Back`).
- Produces the registered 3-bit `state` that the monitor samples, closing the loop between the two blocks.

## Interface

Parameters:
- INIT_TIME, 4: cycles spent all-red in init_state.
- GREEN_MIN, 20: minimum green occupancy, in cycles.
- YELLOW_TIME, 5: exact yellow duration, in cycles.
- IDLE_LIMIT, 100: `Traffic_gone` value at or above which a green phase drops to blink. Legal range 1..127.
- BACK_LIMIT, 3: `Traffic_Back` value at or above which blink exits. Legal range 1..15.
- BLINK_HALF, 8: cycles per blink half-period.
- All time parameters: 1..255.

Ports:
- CLK, in, 1: the single clock. All registers update on the rising edge.
- Reset_n, in, 1: asynchronous, active-low reset.
- A_Traffic, in, 1: vehicle present on road A.
- B_Traffic, in, 1: vehicle present on road B.
- Traffic_gone, in, 7: consecutive no-traffic cycle count from the monitor.
- Traffic_Back, in, 4: consecutive traffic-present cycles while in blink, from the monitor.
- state, out, 3: current phase, registered. Encoding: init_state=0, A_state=1 (A yellow), B_state=2 (B yellow), A_is_green=3, B_is_green=4, Blink_state=5.
- LightA, out, 2: head A. Encoding: 00 off, 01 green, 10 yellow, 11 red.
- LightB, out, 2: head B, same encoding as LightA.

## Operation

Internal registers:
- 8-bit phase timer: cleared on every state change, otherwise increments each cycle. Saturates at 255.
- 8-bit blink timer.
- 1-bit blink phase.

State transitions, evaluated at each rising edge. Conditions are taken on the current state and on inputs sampled at that edge.
- init_state
  - Lights: A red, B red.
  - When timer == INIT_TIME-1 → A_is_green.
- A_is_green
  - Lights: A green, B red.
  - Priority 1: `Traffic_gone` >= IDLE_LIMIT → Blink_state, regardless of timer.
  - Priority 2: timer >= GREEN_MIN-1 and B_Traffic == 1 → A_state.
  - Otherwise hold. Green is held indefinitely while B_Traffic == 0 and the idle limit is not reached.
- A_state
  - Lights: A yellow, B red.
  - When timer == YELLOW_TIME-1 → B_is_green.
  - The idle condition is ignored; yellow always completes.
- B_is_green
  - Mirror of A_is_green, with A_Traffic as the request.
  - Exits to B_state or Blink_state.
- B_state
  - Mirror of A_state.
  - Exits to A_is_green.
- Blink_state
  - Both heads show yellow when blink phase = 1, off when blink phase = 0.
  - On entry: blink phase = 1, blink timer = 0.
  - Blink phase toggles and the blink timer clears when blink timer == BLINK_HALF-1.
  - When `Traffic_Back` >= BACK_LIMIT → init_state (all-red restart).
- Codes 6 and 7
  - Both heads red.
  - Next state is init_state.

Rules:
- Lights are a combinational decode of the state register and the blink phase. No extra register stage.
- Lights change in the same cycle as `state`.
- Both heads are never green or yellow in conflicting combinations. In any non-blink state, at least one head is red.

## Timing

- Reset values: state = 0, LightA = 11, LightB = 11, phase timer = 0, blink timer = 0, blink phase = 0.
- Reset_n low forces these values immediately, without waiting for a clock edge.
- After reset release, the first edge counts as init timer cycle 0.
- Latency: a condition true at edge N produces the new `state` and lights right after edge N. One cycle from input to output.
- Phase durations:
  - init: exactly INIT_TIME cycles.
  - Yellow: exactly YELLOW_TIME cycles.
  - Green: at least GREEN_MIN cycles.
- Monitor loop: the monitor only counts `Traffic_Back` while state == 5. Its count lags by one cycle; no compensation is done here.
- Simultaneous events in green (idle limit and request on the same edge): the idle limit wins. In practice this cannot happen unless the monitor is faulty.
- Reset asserted mid-phase: the phase is abandoned and the controller restarts from init with all timers cleared.

## Test plan

- Reset and start-up:
  - Stimulus: Reset_n low, then released.
  - Response: state=0, LightA=LightB=11. After 4 edges: state=3, LightA=01, LightB=11.
- Request handover:
  - Stimulus: B_Traffic=1 held from A_is_green entry.
  - Response: A green for exactly 20 cycles, then state=1 (LightA=10) for exactly 5 cycles, then state=4 (LightB=01, LightA=11).
- Late request:
  - Stimulus: B_Traffic=0 for 40 cycles in A_is_green, then 1.
  - Response: state leaves 3 on the next edge.
- Idle drop:
  - Stimulus: in A_is_green with timer at 3, drive Traffic_gone=100.
  - Response: state=5 after one edge. Lights read 10/10 for 8 cycles, then 00/00 for 8 cycles, repeating.
  - Also check: Traffic_gone=100 presented in A_state does not interrupt yellow.
- Blink exit:
  - Stimulus: in Blink_state, drive Traffic_Back=2 for 10 cycles, then 3.
  - Response: state stays 5 throughout Traffic_Back=2; state=0 with lights 11/11 one edge after Traffic_Back=3.
- Asynchronous reset mid-yellow:
  - Stimulus: drop Reset_n between edges during B_state.
  - Response: state=0 and lights 11/11 before the next edge. After release, a full 4-cycle init precedes A_is_green.
